// File: rtl/regfile_sequencer.sv
// One-instruction-at-a-time register-file sequencer: fetch, operand read, execute wait, writeback,
// with a debug port that borrows the register file between instructions.
module regfile_sequencer #(
    parameter int EXEC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    output logic        fetch,
    input  logic        instr_valid,
    input  logic [31:0] instr_rdata,
    output logic [31:0] instruction,
    output logic        reg_dst,
    output logic        valid_read,
    output logic        valid_write,
    output logic        w_en,
    output logic [31:0] write_data,
    input  logic [31:0] read_data1,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        exec_wb,
    input  logic [31:0] exec_result,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic [31:0] instr_count,
    output logic        exec_err
);
    localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_READ, S_EXEC, S_WB, S_DBG_RD, S_DBG_RSP, S_DBG_WR
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        instruction_q, instruction_d;
    logic               reg_dst_q, reg_dst_d;
    logic [31:0]        write_data_q, write_data_d;
    logic [31:0]        dbg_rdata_q, dbg_rdata_d;
    logic [31:0]        instr_count_q, instr_count_d;
    logic               exec_err_q, exec_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_dbg_q, last_dbg_d;

    always_comb begin
        state_d       = state_q;
        instruction_d = instruction_q;
        reg_dst_d     = reg_dst_q;
        write_data_d  = write_data_q;
        dbg_rdata_d   = dbg_rdata_q;
        instr_count_d = instr_count_q;
        exec_err_d    = exec_err_q;
        cnt_d         = cnt_q;
        last_dbg_d    = last_dbg_q;
        case (state_q)
            S_IDLE: begin
                // After a debug access a waiting instruction gets the next slot, so neither side starves.
                if (dbg_req && !(last_dbg_q && active)) begin
                    last_dbg_d = 1'b1;
                    if (dbg_we) begin
                        state_d       = S_DBG_WR;
                        instruction_d = {11'b0, dbg_addr, 16'b0};
                        reg_dst_d     = 1'b0;
                        write_data_d  = dbg_wdata;
                    end else begin
                        state_d       = S_DBG_RD;
                        instruction_d = {6'b0, dbg_addr, 21'b0};
                    end
                end else if (active) begin
                    state_d    = S_FETCH;
                    last_dbg_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (instr_valid) begin
                    instruction_d = instr_rdata;
                    reg_dst_d     = (instr_rdata[31:26] == 6'd0);
                    state_d       = S_READ;
                end else if (!active) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                cnt_d   = CNT_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (exec_wb) begin
                        write_data_d = exec_result;
                        state_d      = S_WB;
                    end else begin
                        instr_count_d = instr_count_q + 32'd1;
                        state_d       = S_IDLE;
                    end
                end else if (cnt_q == CNT_W'(EXEC_TIMEOUT)) begin
                    exec_err_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                instr_count_d = instr_count_q + 32'd1;
                state_d       = S_IDLE;
            end
            S_DBG_RD: begin
                // ReadData1 is valid while the read strobe is up; capture it so it is stable under the ack.
                dbg_rdata_d = read_data1;
                state_d     = S_DBG_RSP;
            end
            S_DBG_RSP: state_d = S_IDLE;
            S_DBG_WR:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            instruction_q <= 32'd0;
            reg_dst_q     <= 1'b0;
            write_data_q  <= 32'd0;
            dbg_rdata_q   <= 32'd0;
            instr_count_q <= 32'd0;
            exec_err_q    <= 1'b0;
            cnt_q         <= '0;
            last_dbg_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            reg_dst_q     <= reg_dst_d;
            write_data_q  <= write_data_d;
            dbg_rdata_q   <= dbg_rdata_d;
            instr_count_q <= instr_count_d;
            exec_err_q    <= exec_err_d;
            cnt_q         <= cnt_d;
            last_dbg_q    <= last_dbg_d;
        end
    end

    assign fetch       = (state_q == S_FETCH);
    assign valid_read  = (state_q == S_READ) || (state_q == S_DBG_RD);
    assign valid_write = (state_q == S_WB) || (state_q == S_DBG_WR);
    assign w_en        = valid_write;
    assign dbg_ack     = (state_q == S_DBG_RSP) || (state_q == S_DBG_WR);
    assign exec_start  = (state_q == S_EXEC) && (cnt_q == CNT_W'(1));

    assign instruction = instruction_q;
    assign reg_dst     = reg_dst_q;
    assign write_data  = write_data_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign instr_count = instr_count_q;
    assign exec_err    = exec_err_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a register-file model and write/ack scoreboards.
module tb_regfile_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        active = 1'b0;
    logic        fetch;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_rdata = 32'd0;
    logic [31:0] instruction;
    logic        reg_dst;
    logic        valid_read;
    logic        valid_write;
    logic        w_en;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic        exec_start;
    logic        exec_done = 1'b0;
    logic        exec_wb = 1'b0;
    logic [31:0] exec_result = 32'd0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_wdata = 32'd0;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [31:0] instr_count;
    logic        exec_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        bit          is_rd;
        logic [31:0] rdata;
    } ack_t;
    wr_t  wr_q[$];
    ack_t ack_q[$];

    logic [31:0] regs [32];

    regfile_sequencer #(.EXEC_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .active(active), .fetch(fetch),
        .instr_valid(instr_valid), .instr_rdata(instr_rdata),
        .instruction(instruction), .reg_dst(reg_dst), .valid_read(valid_read),
        .valid_write(valid_write), .w_en(w_en), .write_data(write_data),
        .read_data1(read_data1), .exec_start(exec_start), .exec_done(exec_done),
        .exec_wb(exec_wb), .exec_result(exec_result), .dbg_req(dbg_req),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .instr_count(instr_count),
        .exec_err(exec_err)
    );

    always #5 clk = ~clk;

    // Register file: combinational rs read, write on the clock edge.
    assign read_data1 = regs[instruction[25:21]];
    always @(posedge clk) begin
        if (w_en) regs[reg_dst ? instruction[15:11] : instruction[20:16]] <= write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumers: every write strobe and every ack must match a queued expectation.
    always @(negedge clk) begin
        if (reset && w_en) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_w_en", {31'd0, w_en}, 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wb_valid_write", {31'd0, valid_write}, 32'd1);
                chk("wb_addr", {27'd0, reg_dst ? instruction[15:11] : instruction[20:16]}, {27'd0, e.addr});
                chk("wb_data", write_data, e.data);
            end
        end
        if (reset && dbg_ack) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_dbg_ack", {31'd0, dbg_ack}, 32'd0);
            end else begin
                ack_t a;
                a = ack_q.pop_front();
                if (a.is_rd) chk("dbg_rdata", dbg_rdata, a.rdata);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;

        // Reset values
        #2;
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_strobes", {26'd0, fetch, valid_read, w_en, dbg_ack, exec_err, reg_dst}, 32'd0);
        tick();
        reset = 1'b1;

        // ADDU with writeback
        active = 1'b1; instr_rdata = 32'h0022_1820; instr_valid = 1'b1;
        tick();
        chk("t1_fetch", {31'd0, fetch}, 32'd1);
        tick();
        chk("t1_instruction", instruction, 32'h0022_1820);
        chk("t1_reg_dst", {31'd0, reg_dst}, 32'd1);
        chk("t1_valid_read", {31'd0, valid_read}, 32'd1);
        instr_valid = 1'b0; active = 1'b0;
        exec_done = 1'b1; exec_wb = 1'b1; exec_result = 32'h1234_5678;
        wr_q.push_back('{addr: 5'd3, data: 32'h1234_5678});
        tick();
        chk("t1_exec_start", {31'd0, exec_start}, 32'd1);
        chk("t1_read_fell", {31'd0, valid_read}, 32'd0);
        tick();
        chk("t1_w_en", {31'd0, w_en}, 32'd1);
        exec_done = 1'b0;
        tick();
        chk("t1_w_en_done", {31'd0, w_en}, 32'd0);
        chk("t1_count", instr_count, 32'd1);
        tick();
        chk("t1_idle", {31'd0, fetch}, 32'd0);

        // I-type store, delayed fetch, no writeback
        active = 1'b1; instr_rdata = 32'hAC43_0004;
        tick(); tick(); tick();
        chk("t2_fetch_wait", {31'd0, fetch}, 32'd1);
        instr_valid = 1'b1;
        tick();
        chk("t2_instruction", instruction, 32'hAC43_0004);
        chk("t2_reg_dst", {31'd0, reg_dst}, 32'd0);
        instr_valid = 1'b0; active = 1'b0; exec_done = 1'b1; exec_wb = 1'b0;
        tick();
        tick();
        exec_done = 1'b0;
        chk("t2_count", instr_count, 32'd2);
        chk("t2_no_w_en", {31'd0, w_en}, 32'd0);

        // Timeout with EXEC_TIMEOUT=4
        active = 1'b1; instr_rdata = 32'h0109_5020; instr_valid = 1'b1;
        tick(); tick();
        instr_valid = 1'b0; active = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t3_err_before", {31'd0, exec_err}, 32'd0);
        chk("t3_exec_start_late", {31'd0, exec_start}, 32'd0);
        tick();
        chk("t3_err", {31'd0, exec_err}, 32'd1);
        chk("t3_count", instr_count, 32'd2);
        chk("t3_idle", {30'd0, w_en, fetch}, 32'd0);

        // Done on the timeout cycle itself
        active = 1'b1; instr_valid = 1'b1;
        tick(); tick();
        instr_valid = 1'b0; active = 1'b0;
        tick(); tick(); tick(); tick();
        exec_done = 1'b1; exec_wb = 1'b1; exec_result = 32'hA5A5_0F0F;
        wr_q.push_back('{addr: 5'd10, data: 32'hA5A5_0F0F});
        tick();
        chk("t3b_w_en", {31'd0, w_en}, 32'd1);
        exec_done = 1'b0;
        tick();
        chk("t3b_count", instr_count, 32'd3);
        chk("t3b_err_sticky", {31'd0, exec_err}, 32'd1);

        // Debug write then read of r5
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hCAFE_F00D;
        wr_q.push_back('{addr: 5'd5, data: 32'hCAFE_F00D});
        ack_q.push_back('{is_rd: 1'b0, rdata: 32'd0});
        tick();
        chk("t4_wr_instruction", instruction, 32'h0005_0000);
        chk("t4_wr_reg_dst", {31'd0, reg_dst}, 32'd0);
        chk("t4_wr_strobes", {30'd0, w_en, dbg_ack}, 32'd3);
        dbg_req = 1'b0;
        tick();
        chk("t4_wr_ack_done", {31'd0, dbg_ack}, 32'd0);
        dbg_req = 1'b1; dbg_we = 1'b0;
        ack_q.push_back('{is_rd: 1'b1, rdata: 32'hCAFE_F00D});
        tick();
        chk("t4_rd_instruction", instruction, 32'h00A0_0000);
        chk("t4_rd_valid_read", {31'd0, valid_read}, 32'd1);
        chk("t4_rd_no_ack", {31'd0, dbg_ack}, 32'd0);
        tick();
        chk("t4_rd_ack", {31'd0, dbg_ack}, 32'd1);
        dbg_req = 1'b0;
        tick();

        // Debug raised mid-EXEC, then alternation with both requests held
        active = 1'b1; instr_rdata = 32'h0085_3020; instr_valid = 1'b1;
        tick(); tick();
        instr_valid = 1'b0;
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        tick();
        chk("t5_no_dbg_read", {30'd0, valid_read, dbg_ack}, 32'd0);
        exec_done = 1'b1; exec_wb = 1'b1; exec_result = 32'h0BAD_BEEF;
        wr_q.push_back('{addr: 5'd6, data: 32'h0BAD_BEEF});
        tick();
        chk("t5_wb_no_ack", {31'd0, dbg_ack}, 32'd0);
        exec_done = 1'b0;
        tick();
        chk("t5_count", instr_count, 32'd4);
        ack_q.push_back('{is_rd: 1'b1, rdata: 32'hCAFE_F00D});
        tick();
        chk("t5_dbg_rd", {31'd0, valid_read}, 32'd1);
        tick();
        chk("t5_dbg_ack", {31'd0, dbg_ack}, 32'd1);
        tick();
        tick();
        chk("t5_fetch_after_dbg", {31'd0, fetch}, 32'd1);
        instr_rdata = 32'hAC00_0000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; exec_done = 1'b1; exec_wb = 1'b0;
        tick(); tick();
        exec_done = 1'b0;
        chk("t5_count2", instr_count, 32'd5);
        ack_q.push_back('{is_rd: 1'b1, rdata: 32'hCAFE_F00D});
        tick();
        chk("t5_dbg_again", {31'd0, valid_read}, 32'd1);
        tick();
        chk("t5_dbg_ack2", {31'd0, dbg_ack}, 32'd1);
        dbg_req = 1'b0;
        tick();

        // Asynchronous reset in EXEC with done pending
        instr_rdata = 32'h0022_1820; instr_valid = 1'b1;
        tick(); tick();
        instr_valid = 1'b0; exec_done = 1'b1; exec_wb = 1'b1; exec_result = 32'hDEAD_0000;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_instruction", instruction, 32'd0);
        chk("t6_write_data", write_data, 32'd0);
        chk("t6_dbg_rdata", dbg_rdata, 32'd0);
        chk("t6_count", instr_count, 32'd0);
        chk("t6_flags", {25'd0, fetch, valid_read, w_en, dbg_ack, exec_err, reg_dst, exec_start}, 32'd0);
        tick();
        chk("t6_held_w_en", {31'd0, w_en}, 32'd0);
        exec_done = 1'b0;
        reset = 1'b1;
        tick();
        chk("t6_fetch_resume", {31'd0, fetch}, 32'd1);
        active = 1'b0;
        tick();
        chk("t6_idle", {31'd0, fetch}, 32'd0);

        chk("wr_queue_empty", wr_q.size(), 32'd0);
        chk("ack_queue_empty", ack_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
